board_display_step_driver: RTL

//  Board-side companion to the multi-cycle CPU top. Debounces the step push-button into the CPU's

---
 rtl/board_display_step_driver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/board_display_step_driver.sv
// Step-button debouncer driving the CPU single-step clock, plus a
// 4-digit multiplexed 7-segment scanner for the CPU debug words.
module board_display_step_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  page_sel,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  input  logic        sign5,
  output logic        cpu_clk,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_W,
    HELD,
    REL_W
  } deb_state_t;

  deb_state_t      state;
  deb_state_t      state_nxt;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   cnt_nxt;
  logic            btn_meta;
  logic            btn_sync;
  logic            armed;
  logic            cpu_clk_nxt;

  // Synchronizer is left unreset so a button held through reset
  // still reads as pressed and does not arm the debouncer.
  always_ff @(posedge CLK) begin
    btn_meta <= btn_step;
    btn_sync <= btn_meta;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      cpu_clk <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed | ~btn_sync;
      cpu_clk <= cpu_clk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (armed && btn_sync) begin
          state_nxt = PRESS_W;
          cnt_nxt   = '0;
        end
      end
      PRESS_W: begin
        if (!btn_sync)         state_nxt = IDLE;
        else if (cnt == D_LAST) state_nxt = HELD;
        else                   cnt_nxt = cnt + DW'(1);
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt = REL_W;
          cnt_nxt   = '0;
        end
      end
      REL_W: begin
        if (btn_sync)          state_nxt = HELD;
        else if (cnt == D_LAST) state_nxt = IDLE;
        else                   cnt_nxt = cnt + DW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // Low falls with entry to HELD; release keeps it low one extra cycle.
    cpu_clk_nxt = !(state_nxt == HELD || state_nxt == REL_W ||
                    state == REL_W);
  end

  logic [SW-1:0] scnt;
  logic [1:0]    idx;
  logic [15:0]   snapshot;
  logic [15:0]   page_word;
  logic [3:0]    nibble;
  logic [6:0]    hex7;

  always_comb begin
    page_word = sign1;
    unique case (1'b1)
      page_sel == 2'b00: page_word = sign1;
      page_sel == 2'b01: page_word = sign2;
      page_sel == 2'b10: page_word = sign3;
      page_sel == 2'b11: page_word = sign4;
    endcase
  end

  assign nibble = snapshot[{idx, 2'b00} +: 4];

  always_comb begin
    hex7 = 7'b1111111;
    case (nibble)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  end

  // Snapshot only at frame wrap so all four digits show one word.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      scnt     <= '0;
      idx      <= 2'd0;
      snapshot <= 16'h0000;
      an       <= 4'b1111;
      seg      <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= {(idx == 2'd0) ? ~sign5 : 1'b1, hex7};
      if (scnt == S_LAST) begin
        scnt <= '0;
        idx  <= idx + 2'd1;
        if (idx == 2'd3) snapshot <= page_word;
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end

endmodule
